trap_ctrl: RTL and testbench

// Trap sequencer between the execute stage and the CSR file. Accepts exception flags, mret and the CSR

---
 rtl/trap_ctrl_if.sv | 21 ++
 rtl/trap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// ----------------------------------------------------------------------------
// trap_ctrl_if
// Trap channel between the trap sequencer and the CSR file.
//   we    : write enable (sequencer -> CSR file)
//   addr  : 12-bit CSR address (sequencer -> CSR file)
//   wdata : write data (sequencer -> CSR file)
//   rdata : combinational read data of the CSR at addr (CSR file -> sequencer)
// modport master : trap sequencer side
// modport slave  : CSR file side
// ----------------------------------------------------------------------------
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            we;
  logic [11:0]     addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl
// Trap sequencer between the execute stage and the CSR file. On an exception
// or an enabled interrupt it holds the pipeline, writes mepc, mcause, mtval
// and mstatus over the trap channel (one CSR per cycle), reads mtvec and
// redirects fetch. On mret it restores mstatus.MIE from MPIE and redirects
// fetch to mepc.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_irq_i/tcmp_irq_i/soft_irq_i  masked interrupt requests (causes 11/7/3)
//   mstatus_mie_i              global interrupt enable
//   mepc_i                     current mepc from the CSR file
//   inst_valid_i, pc_i, next_pc_i, inst_i   retiring instruction
//   ecall_i/ebreak_i/illegal_i/mret_i       decoded events
//   csr                        trap channel (master side)
//   hold_o                     pipeline stall
//   jump_o, jump_addr_o        one-cycle fetch redirect
// ----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int VECTORED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_irq_i,
  input  logic             tcmp_irq_i,
  input  logic             soft_irq_i,
  input  logic             mstatus_mie_i,
  input  logic [XLEN-1:0]  mepc_i,
  input  logic             inst_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  next_pc_i,
  input  logic [31:0]      inst_i,
  input  logic             ecall_i,
  input  logic             ebreak_i,
  input  logic             illegal_i,
  input  logic             mret_i,
  trap_ctrl_if.master      csr,
  output logic             hold_o,
  output logic             jump_o,
  output logic [XLEN-1:0]  jump_addr_o
);

  localparam logic [XLEN-1:0] IRQ_BIT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, S_EPC, S_CAUSE, S_TVAL, S_STAT, S_JUMP, M_STAT, M_JUMP
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;

  logic            exc_any;
  logic            irq_any;
  logic            acc_trap;
  logic            acc_mret;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] epc_d;
  logic [XLEN-1:0] tval_d;
  logic [XLEN-1:0] tvec_base;

  // Accept decode: exceptions beat mret, mret beats any pending interrupt.
  always_comb begin
    exc_any  = illegal_i | ecall_i | ebreak_i;
    irq_any  = mstatus_mie_i & (ex_irq_i | soft_irq_i | tcmp_irq_i);
    acc_trap = inst_valid_i & (exc_any | (~mret_i & irq_any));
    acc_mret = inst_valid_i & ~exc_any & mret_i;

    cause_d = '0;
    epc_d   = pc_i;
    tval_d  = '0;
    if (illegal_i) begin
      cause_d = XLEN'(2);
      tval_d  = XLEN'(inst_i);
    end else if (ecall_i) begin
      cause_d = XLEN'(11);
    end else if (ebreak_i) begin
      cause_d = XLEN'(3);
      tval_d  = pc_i;
    end else begin
      // Interrupt: the current instruction completes, so resume after it.
      epc_d = next_pc_i;
      if (ex_irq_i)        cause_d = IRQ_BIT | XLEN'(11);
      else if (soft_irq_i) cause_d = IRQ_BIT | XLEN'(3);
      else                 cause_d = IRQ_BIT | XLEN'(7);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_trap) begin
            state_q <= S_EPC;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
          end else if (acc_mret) begin
            state_q <= M_STAT;
          end
        end
        S_EPC:   state_q <= S_CAUSE;
        S_CAUSE: state_q <= S_TVAL;
        S_TVAL:  state_q <= S_STAT;
        S_STAT:  state_q <= S_JUMP;
        M_STAT:  state_q <= M_JUMP;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; the mstatus updates and the mtvec
  // target are read-modify-write against the combinational read data.
  always_comb begin
    csr.we      = 1'b0;
    csr.addr    = 12'h000;
    csr.wdata   = '0;
    hold_o      = 1'b1;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    tvec_base   = {csr.rdata[XLEN-1:2], 2'b00};
    case (state_q)
      IDLE: begin
        // Stall already in the accept cycle; forced low while in reset.
        hold_o = rst_n & (acc_trap | acc_mret);
      end
      S_EPC: begin
        csr.we    = 1'b1;
        csr.addr  = 12'h341;
        csr.wdata = epc_q;
      end
      S_CAUSE: begin
        csr.we    = 1'b1;
        csr.addr  = 12'h342;
        csr.wdata = cause_q;
      end
      S_TVAL: begin
        csr.we    = 1'b1;
        csr.addr  = 12'h343;
        csr.wdata = tval_q;
      end
      S_STAT: begin
        // MPIE <= MIE, MIE <= 0
        csr.we    = 1'b1;
        csr.addr  = 12'h300;
        csr.wdata = {csr.rdata[XLEN-1:8], csr.rdata[3], csr.rdata[6:4],
                     1'b0, csr.rdata[2:0]};
      end
      S_JUMP: begin
        csr.addr = 12'h305;
        jump_o   = 1'b1;
        if (VECTORED_EN != 0 && csr.rdata[1:0] == 2'b01 && cause_q[XLEN-1])
          jump_addr_o = tvec_base + {cause_q[XLEN-3:0], 2'b00};
        else
          jump_addr_o = tvec_base;
      end
      M_STAT: begin
        // MIE <= MPIE, MPIE <= 1
        csr.we    = 1'b1;
        csr.addr  = 12'h300;
        csr.wdata = {csr.rdata[XLEN-1:8], 1'b1, csr.rdata[6:4],
                     csr.rdata[7], csr.rdata[2:0]};
      end
      M_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: hold_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ex_irq, tcmp_irq, soft_irq;
  logic        inst_valid, ecall, ebreak, illegal, mret;
  logic [31:0] pc, next_pc, inst;
  logic        hold, jump, hold_d, jump_d;
  logic [31:0] jaddr, jaddr_d;

  // CSR file model
  logic [31:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mcause, csr_mtval;
  logic        ld_req;
  logic [31:0] ld_mstatus, ld_mtvec, ld_mepc;

  trap_ctrl_if #(.XLEN(32)) bus ();
  trap_ctrl_if #(.XLEN(32)) bus_d ();

  trap_ctrl #(.XLEN(32), .VECTORED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ex_irq_i(ex_irq), .tcmp_irq_i(tcmp_irq),
    .soft_irq_i(soft_irq), .mstatus_mie_i(csr_mstatus[3]), .mepc_i(csr_mepc),
    .inst_valid_i(inst_valid), .pc_i(pc), .next_pc_i(next_pc), .inst_i(inst),
    .ecall_i(ecall), .ebreak_i(ebreak), .illegal_i(illegal), .mret_i(mret),
    .csr(bus.master), .hold_o(hold), .jump_o(jump), .jump_addr_o(jaddr)
  );

  // Direct-mode instance: only its jump target is observed.
  trap_ctrl #(.XLEN(32), .VECTORED_EN(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .ex_irq_i(ex_irq), .tcmp_irq_i(tcmp_irq),
    .soft_irq_i(soft_irq), .mstatus_mie_i(csr_mstatus[3]), .mepc_i(csr_mepc),
    .inst_valid_i(inst_valid), .pc_i(pc), .next_pc_i(next_pc), .inst_i(inst),
    .ecall_i(ecall), .ebreak_i(ebreak), .illegal_i(illegal), .mret_i(mret),
    .csr(bus_d.master), .hold_o(hold_d), .jump_o(jump_d), .jump_addr_o(jaddr_d)
  );

  always_comb begin
    case (bus.addr)
      12'h300: bus.rdata = csr_mstatus;
      12'h305: bus.rdata = csr_mtvec;
      12'h341: bus.rdata = csr_mepc;
      12'h342: bus.rdata = csr_mcause;
      12'h343: bus.rdata = csr_mtval;
      default: bus.rdata = 32'h0;
    endcase
  end

  always_comb begin
    case (bus_d.addr)
      12'h300: bus_d.rdata = csr_mstatus;
      12'h305: bus_d.rdata = csr_mtvec;
      12'h341: bus_d.rdata = csr_mepc;
      12'h342: bus_d.rdata = csr_mcause;
      12'h343: bus_d.rdata = csr_mtval;
      default: bus_d.rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (ld_req) begin
      csr_mstatus <= ld_mstatus;
      csr_mtvec   <= ld_mtvec;
      csr_mepc    <= ld_mepc;
    end else if (bus.we) begin
      case (bus.addr)
        12'h300: csr_mstatus <= bus.wdata;
        12'h341: csr_mepc    <= bus.wdata;
        12'h342: csr_mcause  <= bus.wdata;
        12'h343: csr_mtval   <= bus.wdata;
        default: ;
      endcase
    end
  end

  int passed = 0;
  int total  = 0;

  int          jc, hc, jn;
  logic [31:0] ja, jad;
  logic        wj;

  task automatic clear_inst();
    inst_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0;
  endtask

  task automatic preload(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
    ld_mstatus = ms; ld_mtvec = tv; ld_mepc = ep; ld_req = 1'b1;
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  // Called with accept-cycle inputs already applied; observes 8 cycles.
  task automatic run_seq(output int jc_o, output logic [31:0] ja_o, output logic [31:0] jad_o,
                         output int hc_o, output int jn_o, output logic wj_o);
    #1;
    hc_o = hold ? 1 : 0; jc_o = -1; jn_o = 0; ja_o = '0; jad_o = '0; wj_o = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin clear_inst(); #1; end
      if (hold) hc_o++;
      if (jump) begin
        jn_o++;
        if (jc_o < 0) jc_o = c;
        ja_o = jaddr;
        wj_o = bus.we;
      end
      if (jump_d) jad_o = jaddr_d;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_req = 1'b0;
    ex_irq = 0; tcmp_irq = 0; soft_irq = 0; clear_inst();
    pc = 0; next_pc = 0; inst = 0;
    preload(32'h8, 32'h1000, 32'h0);
    @(posedge clk); #1;
    total++; if (hold !== 1'b0) $display("FAIL reset_hold: got %b want 0", hold); else passed++;
    total++; if (jump !== 1'b0) $display("FAIL reset_jump: got %b want 0", jump); else passed++;
    total++; if (bus.we !== 1'b0 || bus.addr !== 12'h0 || bus.wdata !== 32'h0)
      $display("FAIL reset_csr: got we=%b addr=%h wdata=%h want 0/000/0", bus.we, bus.addr, bus.wdata);
    else passed++;
    total++; if (jaddr !== 32'h0) $display("FAIL reset_jaddr: got %h want 0", jaddr); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: hold=%b jump=%b", hold, jump);
  endtask

  task automatic test_timer_irq();
    // MIE=0 masks the interrupt entirely
    preload(32'h0, 32'h1000, 32'h0);
    tcmp_irq = 1; inst_valid = 1; pc = 32'h100; next_pc = 32'h104;
    #1;
    total++; if (hold !== 1'b0) $display("FAIL irq_masked_hold: got %b want 0", hold); else passed++;
    clear_inst(); tcmp_irq = 0;
    preload(32'h8, 32'h1000, 32'h0);
    tcmp_irq = 1; inst_valid = 1; pc = 32'h100; next_pc = 32'h104;
    run_seq(jc, ja, jad, hc, jn, wj);
    tcmp_irq = 0;
    $display("timer irq: mepc=%h mcause=%h mtval=%h mstatus=%h jump@%0d addr=%h hold=%0d",
             csr_mepc, csr_mcause, csr_mtval, csr_mstatus, jc, ja, hc);
    total++; if (csr_mepc !== 32'h104) $display("FAIL tmr_mepc: got %h want 104", csr_mepc); else passed++;
    total++; if (csr_mcause !== 32'h80000007) $display("FAIL tmr_mcause: got %h want 80000007", csr_mcause); else passed++;
    total++; if (csr_mtval !== 32'h0) $display("FAIL tmr_mtval: got %h want 0", csr_mtval); else passed++;
    total++; if (csr_mstatus !== 32'h80) $display("FAIL tmr_mstatus: got %h want 80", csr_mstatus); else passed++;
    total++; if (jc !== 5) $display("FAIL tmr_latency: got %0d want 5", jc); else passed++;
    total++; if (ja !== 32'h1000) $display("FAIL tmr_jaddr: got %h want 1000", ja); else passed++;
    total++; if (hc !== 6) $display("FAIL tmr_hold_cycles: got %0d want 6", hc); else passed++;
    total++; if (jn !== 1) $display("FAIL tmr_jump_width: got %0d want 1", jn); else passed++;
    total++; if (wj !== 1'b0) $display("FAIL tmr_we_at_jump: got %b want 0", wj); else passed++;
  endtask

  task automatic test_ext_vectored();
    preload(32'h8, 32'h2001, 32'h0);
    ex_irq = 1; tcmp_irq = 1; inst_valid = 1; pc = 32'h300; next_pc = 32'h304;
    run_seq(jc, ja, jad, hc, jn, wj);
    ex_irq = 0; tcmp_irq = 0;
    $display("ext irq vectored: mcause=%h mepc=%h addr=%h direct_addr=%h", csr_mcause, csr_mepc, ja, jad);
    total++; if (csr_mcause !== 32'h8000000B) $display("FAIL ext_mcause: got %h want 8000000B", csr_mcause); else passed++;
    total++; if (csr_mepc !== 32'h304) $display("FAIL ext_mepc: got %h want 304", csr_mepc); else passed++;
    total++; if (ja !== 32'h202C) $display("FAIL ext_vec_jaddr: got %h want 202C", ja); else passed++;
    total++; if (jad !== 32'h2000) $display("FAIL ext_direct_jaddr: got %h want 2000", jad); else passed++;
  endtask

  task automatic test_illegal();
    preload(32'h0, 32'h1000, 32'h0);
    illegal = 1; ecall = 1; inst_valid = 1; inst = 32'hFFFFFFFF; pc = 32'h200; next_pc = 32'h204;
    run_seq(jc, ja, jad, hc, jn, wj);
    $display("illegal: mepc=%h mcause=%h mtval=%h mstatus=%h addr=%h", csr_mepc, csr_mcause, csr_mtval, csr_mstatus, ja);
    total++; if (csr_mepc !== 32'h200) $display("FAIL ill_mepc: got %h want 200", csr_mepc); else passed++;
    total++; if (csr_mcause !== 32'h2) $display("FAIL ill_mcause: got %h want 2", csr_mcause); else passed++;
    total++; if (csr_mtval !== 32'hFFFFFFFF) $display("FAIL ill_mtval: got %h want FFFFFFFF", csr_mtval); else passed++;
    total++; if (csr_mstatus !== 32'h0) $display("FAIL ill_mstatus: got %h want 0", csr_mstatus); else passed++;
    total++; if (ja !== 32'h1000) $display("FAIL ill_jaddr: got %h want 1000", ja); else passed++;
  endtask

  task automatic test_mret();
    preload(32'h80, 32'h1000, 32'h104);
    mret = 1; inst_valid = 1; pc = 32'h50; next_pc = 32'h54;
    run_seq(jc, ja, jad, hc, jn, wj);
    $display("mret: mstatus=%h jump@%0d addr=%h hold=%0d", csr_mstatus, jc, ja, hc);
    total++; if (csr_mstatus !== 32'h88) $display("FAIL mret_mstatus: got %h want 88", csr_mstatus); else passed++;
    total++; if (jc !== 2) $display("FAIL mret_latency: got %0d want 2", jc); else passed++;
    total++; if (ja !== 32'h104) $display("FAIL mret_jaddr: got %h want 104", ja); else passed++;
    total++; if (hc !== 3) $display("FAIL mret_hold_cycles: got %0d want 3", hc); else passed++;
    total++; if (jn !== 1) $display("FAIL mret_jump_width: got %0d want 1", jn); else passed++;
  endtask

  task automatic test_back_to_back();
    preload(32'h8, 32'h1000, 32'h0);
    ecall = 1; soft_irq = 1; inst_valid = 1; pc = 32'h400; next_pc = 32'h404;
    run_seq(jc, ja, jad, hc, jn, wj);
    $display("ecall+soft: mcause=%h mepc=%h mtval=%h addr=%h", csr_mcause, csr_mepc, csr_mtval, ja);
    total++; if (csr_mcause !== 32'hB) $display("FAIL b2b_ecall_mcause: got %h want B", csr_mcause); else passed++;
    total++; if (csr_mepc !== 32'h400) $display("FAIL b2b_ecall_mepc: got %h want 400", csr_mepc); else passed++;
    total++; if (csr_mtval !== 32'h0) $display("FAIL b2b_ecall_mtval: got %h want 0", csr_mtval); else passed++;
    // MIE forced on so the pending soft irq competes with mret
    preload(32'h88, 32'h1000, 32'h400);
    mret = 1; inst_valid = 1; pc = 32'h408; next_pc = 32'h40C;
    run_seq(jc, ja, jad, hc, jn, wj);
    $display("mret vs soft: mcause=%h jump@%0d addr=%h", csr_mcause, jc, ja);
    total++; if (jc !== 2) $display("FAIL b2b_mret_latency: got %0d want 2", jc); else passed++;
    total++; if (ja !== 32'h400) $display("FAIL b2b_mret_jaddr: got %h want 400", ja); else passed++;
    total++; if (csr_mcause !== 32'hB) $display("FAIL b2b_mret_mcause: got %h want B", csr_mcause); else passed++;
    inst_valid = 1; pc = 32'h410; next_pc = 32'h414;
    run_seq(jc, ja, jad, hc, jn, wj);
    soft_irq = 0;
    $display("soft after mret: mcause=%h mepc=%h jump@%0d", csr_mcause, csr_mepc, jc);
    total++; if (csr_mcause !== 32'h80000003) $display("FAIL b2b_soft_mcause: got %h want 80000003", csr_mcause); else passed++;
    total++; if (csr_mepc !== 32'h414) $display("FAIL b2b_soft_mepc: got %h want 414", csr_mepc); else passed++;
    total++; if (jc !== 5) $display("FAIL b2b_soft_latency: got %0d want 5", jc); else passed++;
  endtask

  task automatic test_reset_mid();
    int jumps;
    preload(32'h8, 32'h1000, 32'h0);
    ecall = 1; inst_valid = 1; pc = 32'h600; next_pc = 32'h604;
    @(posedge clk); #1;
    clear_inst();
    @(posedge clk); #1;
    total++; if (bus.we !== 1'b1 || bus.addr !== 12'h342)
      $display("FAIL mid_in_cause: got we=%b addr=%h want 1/342", bus.we, bus.addr);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (hold !== 1'b0 || jump !== 1'b0) $display("FAIL mid_rst_hj: got hold=%b jump=%b want 0/0", hold, jump); else passed++;
    total++; if (bus.we !== 1'b0 || bus.addr !== 12'h0 || bus.wdata !== 32'h0)
      $display("FAIL mid_rst_csr: got we=%b addr=%h wdata=%h want 0/000/0", bus.we, bus.addr, bus.wdata);
    else passed++;
    jumps = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (jump) jumps++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (jump || hold) jumps++;
    end
    $display("reset mid-trap: mepc=%h stray_jump_or_hold=%0d", csr_mepc, jumps);
    total++; if (jumps !== 0) $display("FAIL mid_no_jump: got %0d want 0", jumps); else passed++;
    total++; if (csr_mepc !== 32'h600) $display("FAIL mid_partial_mepc: got %h want 600", csr_mepc); else passed++;
    // ebreak from the recovered IDLE state
    ebreak = 1; inst_valid = 1; pc = 32'h700; next_pc = 32'h704;
    run_seq(jc, ja, jad, hc, jn, wj);
    $display("ebreak after reset: mcause=%h mtval=%h jump@%0d", csr_mcause, csr_mtval, jc);
    total++; if (csr_mcause !== 32'h3) $display("FAIL ebrk_mcause: got %h want 3", csr_mcause); else passed++;
    total++; if (csr_mtval !== 32'h700) $display("FAIL ebrk_mtval: got %h want 700", csr_mtval); else passed++;
    total++; if (jc !== 5) $display("FAIL ebrk_latency: got %0d want 5", jc); else passed++;
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_ext_vectored();
    test_illegal();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
